// File: rtl/cnt_down_pkg.sv
// Shared definitions for the cnt_down countdown stage.
//   - FSM state encoding (legacy 2-bit constants)
//   - presc_w(): width of the prescale counter, never less than 1 bit
package cnt_down_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int presc_w(input int p);
    if (p <= 1) return 1;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/cnt_down_if.sv
// Control/status bundle of one cnt_down stage.
//   master : the controller (drives load/start/pause/tick_in/wrap_en)
//   slave  : the counter (drives sum/borrow/done/busy)
interface cnt_down_if #(
  parameter int BITS = 8
);

  logic            load;
  logic [BITS-1:0] load_val;
  logic            start;
  logic            pause;
  logic            tick_in;
  logic            wrap_en;
  logic [BITS-1:0] sum;
  logic            borrow;
  logic            done;
  logic            busy;

  modport master (
    output load, load_val, start, pause, tick_in, wrap_en,
    input  sum, borrow, done, busy
  );

  modport slave (
    input  load, load_val, start, pause, tick_in, wrap_en,
    output sum, borrow, done, busy
  );

endinterface

// File: rtl/cnt_down_tick_prescale.sv
// Tick prescaler: counts qualified ticks and asserts step on the tick that
// completes a group of PRESCALE ticks.
//   clk, reset : system clock, async active-high reset
//   clear      : synchronous restart of the count (driven by load)
//   tick_q     : qualified tick
//   step       : combinational, high on the PRESCALE-th tick of a group
module cnt_down_tick_prescale
  import cnt_down_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick_q,
  output logic step
);

  localparam int            W    = presc_w(PRESCALE);
  localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  // Step is not registered so the sum update lands one clock after tick_in.
  assign step = tick_q && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick_q) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/cnt_down.sv
// Modulo-MAX down counter stage with load, start/pause control and a borrow
// pulse for cascading (borrow of one stage drives tick_in of the next).
//   clk, reset : system clock, async active-high reset
//   bus        : cnt_down_if slave -- load/load_val/start/pause/tick_in/
//                wrap_en in, sum/borrow/done/busy out (all registered)
module cnt_down
  import cnt_down_pkg::*;
#(
  parameter int MAX      = 10,
  parameter int BITS     = 8,
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  cnt_down_if.slave  bus
);

  localparam logic [BITS-1:0] TOP = BITS'(MAX - 1);

  logic [1:0]      state, state_n;
  logic [BITS-1:0] sum_q, sum_n;
  logic            borrow_q, borrow_n;
  logic            done_q, busy_q;
  logic            tick_q, step;

  // A tick only counts while running, and loses to pause and load.
  assign tick_q = (state == ST_RUN) && bus.tick_in && !bus.pause && !bus.load;

  cnt_down_tick_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.load),
    .tick_q (tick_q),
    .step   (step)
  );

  always_comb begin
    state_n  = state;
    sum_n    = sum_q;
    borrow_n = 1'b0;
    if (bus.load) begin
      state_n = ST_IDLE;
      sum_n   = (bus.load_val > TOP) ? TOP : bus.load_val;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start)
            state_n = (sum_q == '0 && !bus.wrap_en) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_n = ST_PAUSE;
          end else if (step) begin
            if (sum_q != '0) begin
              sum_n = sum_q - BITS'(1);
              if (sum_q == BITS'(1) && !bus.wrap_en)
                state_n = ST_DONE;
            end else if (bus.wrap_en) begin
              sum_n    = TOP;
              borrow_n = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.start && !bus.pause)
            state_n = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  // Register stage: state and every output are updated together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      sum_q    <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sum_q    <= sum_n;
      borrow_q <= borrow_n;
      done_q   <= (state_n == ST_DONE);
      busy_q   <= (state_n == ST_RUN);
    end
  end

  assign bus.sum    = sum_q;
  assign bus.borrow = borrow_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_cnt_down.sv
// Bench for cnt_down: four stages share one stimulus set.
//   0: lo  MAX=10 PRESCALE=1
//   1: hi  MAX=10 PRESCALE=1, tick_in = lo.borrow, own load value
//   2: p4  MAX=10 PRESCALE=4
//   3: m1  MAX=1  PRESCALE=1
// A behavioural model predicts every stage each cycle; literal checks pin it.
module tb_cnt_down;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ld, st, pa, tk, wr;
  logic [7:0] lv, hv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_down_if #(.BITS(8)) if_lo ();
  cnt_down_if #(.BITS(8)) if_hi ();
  cnt_down_if #(.BITS(8)) if_p4 ();
  cnt_down_if #(.BITS(8)) if_m1 ();

  assign if_lo.load = ld;  assign if_lo.load_val = lv;  assign if_lo.start = st;
  assign if_lo.pause = pa; assign if_lo.tick_in = tk;   assign if_lo.wrap_en = wr;
  assign if_hi.load = ld;  assign if_hi.load_val = hv;  assign if_hi.start = st;
  assign if_hi.pause = pa; assign if_hi.tick_in = if_lo.borrow; assign if_hi.wrap_en = wr;
  assign if_p4.load = ld;  assign if_p4.load_val = lv;  assign if_p4.start = st;
  assign if_p4.pause = pa; assign if_p4.tick_in = tk;   assign if_p4.wrap_en = wr;
  assign if_m1.load = ld;  assign if_m1.load_val = lv;  assign if_m1.start = st;
  assign if_m1.pause = pa; assign if_m1.tick_in = tk;   assign if_m1.wrap_en = wr;

  cnt_down #(.MAX(10), .BITS(8), .PRESCALE(1)) u_lo (.clk(clk), .reset(reset), .bus(if_lo));
  cnt_down #(.MAX(10), .BITS(8), .PRESCALE(1)) u_hi (.clk(clk), .reset(reset), .bus(if_hi));
  cnt_down #(.MAX(10), .BITS(8), .PRESCALE(4)) u_p4 (.clk(clk), .reset(reset), .bus(if_p4));
  cnt_down #(.MAX(1),  .BITS(8), .PRESCALE(1)) u_m1 (.clk(clk), .reset(reset), .bus(if_m1));

  logic [7:0] o_sum [4];
  logic       o_brw [4];
  logic       o_don [4];
  logic       o_bsy [4];

  assign o_sum[0] = if_lo.sum; assign o_brw[0] = if_lo.borrow; assign o_don[0] = if_lo.done; assign o_bsy[0] = if_lo.busy;
  assign o_sum[1] = if_hi.sum; assign o_brw[1] = if_hi.borrow; assign o_don[1] = if_hi.done; assign o_bsy[1] = if_hi.busy;
  assign o_sum[2] = if_p4.sum; assign o_brw[2] = if_p4.borrow; assign o_don[2] = if_p4.done; assign o_bsy[2] = if_p4.busy;
  assign o_sum[3] = if_m1.sum; assign o_brw[3] = if_m1.borrow; assign o_don[3] = if_m1.done; assign o_bsy[3] = if_m1.busy;

  // ---------------- behavioural model ----------------
  typedef struct {
    int sum;
    int pc;
    bit run;
    bit hold;
    bit fin;
    bit borrow;
  } mdl_t;

  localparam int MAXS [4] = '{10, 10, 10, 1};
  localparam int PRES [4] = '{1, 1, 4, 1};

  mdl_t m [4];

  function automatic mdl_t mreset();
    mdl_t r;
    r.sum = 0; r.pc = 0; r.run = 0; r.hold = 0; r.fin = 0; r.borrow = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input int mx, input int pre,
                                 input bit l, input int v, input bit s,
                                 input bit p, input bit t, input bit w);
    mdl_t n = c;
    n.borrow = 0;
    if (l) begin
      n = mreset();
      n.sum = (v > mx - 1) ? mx - 1 : v;
    end else if (c.fin) begin
      // finished: only load or reset leaves
    end else if (c.hold) begin
      if (s && !p) begin n.hold = 0; n.run = 1; end
    end else if (c.run) begin
      if (p) begin
        n.run = 0; n.hold = 1;
      end else if (t) begin
        n.pc = c.pc + 1;
        if (n.pc == pre) begin
          n.pc = 0;
          if (c.sum > 0) begin
            n.sum = c.sum - 1;
            if (n.sum == 0 && !w) begin n.run = 0; n.fin = 1; end
          end else if (w) begin
            n.sum = mx - 1;
            n.borrow = 1;
          end
        end
      end
    end else if (s) begin
      if (c.sum == 0 && !w) n.fin = 1;
      else n.run = 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m[i] <= mreset();
    end else begin
      m[0] <= mstep(m[0], MAXS[0], PRES[0], ld, int'(lv), st, pa, tk, wr);
      m[1] <= mstep(m[1], MAXS[1], PRES[1], ld, int'(hv), st, pa, m[0].borrow, wr);
      m[2] <= mstep(m[2], MAXS[2], PRES[2], ld, int'(lv), st, pa, tk, wr);
      m[3] <= mstep(m[3], MAXS[3], PRES[3], ld, int'(lv), st, pa, tk, wr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if ($time > 2) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("mdl%0d_sum", i), 32'(o_sum[i]), m[i].sum);
        chk($sformatf("mdl%0d_borrow", i), 32'(o_brw[i]), 32'(m[i].borrow));
        chk($sformatf("mdl%0d_done", i), 32'(o_don[i]), 32'(m[i].fin));
        chk($sformatf("mdl%0d_busy", i), 32'(o_bsy[i]), 32'(m[i].run));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit l, input logic [7:0] v, input bit s,
                       input bit p, input bit t, input bit w);
    ld = l; lv = v; st = s; pa = p; tk = t; wr = w;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    ld = 0; lv = 0; hv = 0; st = 0; pa = 0; tk = 0; wr = 0;
    #1 reset = 1'b1;
    cyc(); cyc();
    chk("rst_sum", 32'(if_lo.sum), 0);
    chk("rst_busy", 32'(if_lo.busy), 0);
    chk("rst_done", 32'(if_lo.done), 0);
    chk("rst_borrow", 32'(if_lo.borrow), 0);
    reset = 1'b0;

    // stop mode countdown 3,2,1,0
    drive(1, 8'd3, 0, 0, 0, 0); cyc();
    chk("a_load3", 32'(if_lo.sum), 3);
    drive(0, 8'd3, 1, 0, 1, 0); cyc();
    chk("a_start_sum", 32'(if_lo.sum), 3);
    chk("a_start_busy", 32'(if_lo.busy), 1);
    drive(0, 8'd3, 0, 0, 1, 0); cyc();
    chk("a_sum2", 32'(if_lo.sum), 2);
    cyc(); chk("a_sum1", 32'(if_lo.sum), 1);
    cyc(); chk("a_sum0", 32'(if_lo.sum), 0);
    chk("a_done", 32'(if_lo.done), 1);
    chk("a_busy0", 32'(if_lo.busy), 0);
    cyc(); chk("a_hold0", 32'(if_lo.sum), 0);
    chk("a_noborrow", 32'(if_lo.borrow), 0);
    drive(0, 8'd3, 1, 0, 1, 0); cyc();
    chk("a_done_start_ignored", 32'(if_lo.done), 1);
    chk("a_done_busy", 32'(if_lo.busy), 0);

    // wrap from 0 and cascade
    hv = 8'd2;
    drive(1, 8'd0, 0, 0, 0, 1); cyc();
    drive(0, 8'd0, 1, 0, 0, 1); cyc();
    chk("b_busy", 32'(if_lo.busy), 1);
    drive(0, 8'd0, 0, 0, 1, 1); cyc();
    chk("b_wrap_sum", 32'(if_lo.sum), 9);
    chk("b_wrap_borrow", 32'(if_lo.borrow), 1);
    chk("m1_sum", 32'(if_m1.sum), 0);
    chk("m1_borrow", 32'(if_m1.borrow), 1);
    cyc();
    chk("b_sum8", 32'(if_lo.sum), 8);
    chk("b_borrow_low", 32'(if_lo.borrow), 0);
    chk("c_hi1", 32'(if_hi.sum), 1);
    for (int i = 0; i < 9; i++) cyc();
    chk("c_lo_wrap2", 32'(if_lo.sum), 9);
    chk("c_lo_borrow2", 32'(if_lo.borrow), 1);
    drive(0, 8'd0, 0, 0, 0, 1); cyc();
    chk("c_hi0", 32'(if_hi.sum), 0);
    chk("c_lo9", 32'(if_lo.sum), 9);

    // prescale 4 with pause
    drive(1, 8'd2, 0, 0, 0, 0); cyc();
    drive(0, 8'd2, 1, 0, 0, 0); cyc();
    chk("p_busy", 32'(if_p4.busy), 1);
    drive(0, 8'd2, 0, 0, 1, 0);
    cyc(); cyc(); cyc();
    chk("p_tick3", 32'(if_p4.sum), 2);
    cyc(); chk("p_tick4", 32'(if_p4.sum), 1);
    cyc(); cyc(); chk("p_tick6", 32'(if_p4.sum), 1);
    drive(0, 8'd2, 0, 1, 0, 0); cyc();
    chk("p_paused_busy", 32'(if_p4.busy), 0);
    drive(0, 8'd2, 0, 0, 1, 0);
    cyc(); cyc(); cyc();
    chk("p_paused_hold", 32'(if_p4.sum), 1);
    drive(0, 8'd2, 1, 0, 0, 0); cyc();
    chk("p_resume_busy", 32'(if_p4.busy), 1);
    drive(0, 8'd2, 0, 0, 1, 0); cyc();
    chk("p_tick7", 32'(if_p4.sum), 1);
    cyc();
    chk("p_tick8", 32'(if_p4.sum), 0);
    chk("p_done", 32'(if_p4.done), 1);

    // load clamp and load priority
    drive(1, 8'd15, 0, 0, 0, 0); cyc();
    chk("d_clamp", 32'(if_lo.sum), 9);
    chk("d_clamp_m1", 32'(if_m1.sum), 0);
    drive(1, 8'd5, 1, 0, 1, 0); cyc();
    chk("d_prio_sum", 32'(if_lo.sum), 5);
    chk("d_prio_busy", 32'(if_lo.busy), 0);
    drive(0, 8'd5, 0, 0, 1, 0); cyc();
    chk("d_idle_hold", 32'(if_lo.sum), 5);

    // asynchronous reset while running
    drive(0, 8'd5, 1, 0, 0, 0); cyc();
    chk("e_run_busy", 32'(if_lo.busy), 1);
    chk("e_run_sum", 32'(if_lo.sum), 5);
    drive(0, 8'd5, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("e_async_sum", 32'(if_lo.sum), 0);
    chk("e_async_busy", 32'(if_lo.busy), 0);
    chk("e_async_borrow", 32'(if_lo.borrow), 0);
    chk("e_async_done", 32'(if_lo.done), 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("e_after_sum", 32'(if_lo.sum), 0);
    chk("e_after_busy", 32'(if_lo.busy), 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
